aesl_deadlock_axis_monitor_p: RTL and testbench

Parametrised deadlock monitor for HLS co-simulation benches, generalising the fixed three-channel AXI-Stream blocking monitor. It combines N per-channel blocking flags, per-channel idle qualifiers and M sub-instance block flags into a blocked condition, and keeps the legacy one-cycle `block` output for existing hierarchies. It adds a persistence filter: deadlock is declared only after the condition has held for a programmable number of consecutive cycles. The deadlock flag is sticky and carries a snapshot of the offending channels until software or the bench clears it.

---
 rtl/aesl_deadlock_pkg.sv | 32 +++
 rtl/aesl_deadlock_sat_cnt.sv | 33 +++
 rtl/aesl_deadlock_axis_monitor_p.sv | 129 ++++++++++++
 tb/tb_aesl_deadlock_axis_monitor_p.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the parametrised AXI-Stream deadlock monitor.
// Holds the monitor FSM encoding, default widths and the lowest-set-index helper.
package aesl_deadlock_pkg;

    localparam int DEF_NUM_AXIS = 3;
    localparam int DEF_NUM_INST = 1;
    localparam int DEF_THR_W    = 16;
    localparam int DEF_CNT_W    = 32;
    localparam int IDX_MAX_W    = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Only bits below 'width' are considered; callers zero-extend narrower vectors.
    function automatic logic [5:0] lowest_set_idx(input logic [IDX_MAX_W-1:0] vec, input int width);
        logic [5:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < IDX_MAX_W; i++) begin
            if (i < width && vec[i] && !found) begin
                idx   = 6'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/aesl_deadlock_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module aesl_deadlock_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/aesl_deadlock_axis_monitor_p.sv
// Parametrised deadlock monitor: legacy one-cycle block output plus a persistence
// filter that declares a sticky deadlock after the blocked condition holds T cycles.
module aesl_deadlock_axis_monitor_p
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = DEF_NUM_AXIS,
    parameter int NUM_INST = DEF_NUM_INST,
    parameter int THR_W    = DEF_THR_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int IDX_W    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic [NUM_AXIS-1:0] axis_block_sigs_i,
    input  logic [NUM_AXIS-1:0] inst_idle_sigs_i,
    input  logic [NUM_INST-1:0] inst_block_sigs_i,
    input  logic [NUM_AXIS-1:0] chan_mask_i,
    input  logic [THR_W-1:0]    threshold_i,
    input  logic                clear_i,
    output logic                block_o,
    output logic                deadlock_o,
    output logic [NUM_AXIS-1:0] deadlock_chans_o,
    output logic [IDX_W-1:0]    first_chan_o,
    output logic [CNT_W-1:0]    stall_cycles_o
);

    state_e              state_q, state_d;
    logic [THR_W-1:0]    run_q, run_d;
    logic                block_q;
    logic [NUM_AXIS-1:0] chans_q, chans_d;
    logic [IDX_W-1:0]    first_q, first_d;

    logic [NUM_AXIS-1:0] qual;
    logic                raw;
    logic [THR_W-1:0]    thr_eff;
    logic [THR_W:0]      run_inc;
    logic                lock;

    assign qual    = axis_block_sigs_i & chan_mask_i & ~inst_idle_sigs_i;
    assign raw     = (|qual) | (|inst_block_sigs_i);
    assign thr_eff = (threshold_i == '0) ? THR_W'(1) : threshold_i;
    assign run_inc = {1'b0, run_q} + (THR_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        lock    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (raw && thr_eff == THR_W'(1)) begin
                    state_d = ST_LOCKED;
                    lock    = 1'b1;
                end else if (raw) begin
                    state_d = ST_COUNT;
                    run_d   = THR_W'(1);
                end else begin
                    run_d   = '0;
                end
            end
            ST_COUNT: begin
                if (!raw) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else if (run_inc >= {1'b0, thr_eff}) begin
                    state_d = ST_LOCKED;
                    run_d   = '0;
                    lock    = 1'b1;
                end else begin
                    run_d   = run_inc[THR_W-1:0];
                end
            end
            ST_LOCKED: state_d = ST_LOCKED;
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        endcase
        // clear dominates any lock decided in the same cycle
        if (clear_i) begin
            state_d = ST_IDLE;
            run_d   = '0;
            lock    = 1'b0;
        end
    end

    always_comb begin
        chans_d = chans_q;
        first_d = first_q;
        if (clear_i) begin
            chans_d = '0;
            first_d = '0;
        end else if (lock) begin
            chans_d = qual;
            first_d = IDX_W'(lowest_set_idx(IDX_MAX_W'(qual), NUM_AXIS));
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            block_q <= 1'b0;
            chans_q <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            block_q <= raw;
            chans_q <= chans_d;
            first_q <= first_d;
        end
    end

    aesl_deadlock_sat_cnt #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i (clock_i),
        .rst_ni(reset_ni),
        .clr_i (clear_i),
        .inc_i (raw & ~clear_i),
        .cnt_o (stall_cycles_o)
    );

    assign block_o          = block_q;
    assign deadlock_o       = (state_q == ST_LOCKED);
    assign deadlock_chans_o = chans_q;
    assign first_chan_o     = first_q;

endmodule

// File: tb/tb_aesl_deadlock_axis_monitor_p.sv
// Self-checking bench for aesl_deadlock_axis_monitor_p: directed scenarios plus
// randomized traffic compared against a streak-counting reference model.
module tb_aesl_deadlock_axis_monitor_p;

    logic        clk;
    logic        rst_n;
    logic [2:0]  axis;
    logic [2:0]  idle;
    logic [1:0]  inst;
    logic [2:0]  mask;
    logic [15:0] thr;
    logic        clear;
    logic        block;
    logic        deadlock;
    logic [2:0]  chans;
    logic [1:0]  first;
    logic [3:0]  stall;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic       m_block;
    logic       m_locked;
    int         m_streak;
    int         m_stall;
    logic [2:0] m_chans;
    logic [1:0] m_first;

    aesl_deadlock_axis_monitor_p #(
        .NUM_AXIS(3),
        .NUM_INST(2),
        .THR_W   (16),
        .CNT_W   (4)
    ) dut (
        .clock_i          (clk),
        .reset_ni         (rst_n),
        .axis_block_sigs_i(axis),
        .inst_idle_sigs_i (idle),
        .inst_block_sigs_i(inst),
        .chan_mask_i      (mask),
        .threshold_i      (thr),
        .clear_i          (clear),
        .block_o          (block),
        .deadlock_o       (deadlock),
        .deadlock_chans_o (chans),
        .first_chan_o     (first),
        .stall_cycles_o   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_zero();
        m_block  = 1'b0;
        m_locked = 1'b0;
        m_streak = 0;
        m_stall  = 0;
        m_chans  = '0;
        m_first  = '0;
    endtask

    task automatic quiet_inputs();
        axis  = '0;
        idle  = '0;
        inst  = '0;
        mask  = 3'b111;
        clear = 1'b0;
    endtask

    // One clock: advance to the edge, then update the model from the inputs applied.
    task automatic cycle();
        logic [2:0] q;
        logic       raw;
        int         t;
        q   = axis & mask & ~idle;
        raw = (q != 0) || (inst != 0);
        t   = (thr == 0) ? 1 : int'(thr);
        @(posedge clk);
        #1;
        m_block = raw;
        if (clear) begin
            m_locked = 1'b0;
            m_streak = 0;
            m_stall  = 0;
            m_chans  = '0;
            m_first  = '0;
        end else begin
            if (raw && m_stall < 15) m_stall++;
            if (!m_locked) begin
                m_streak = raw ? m_streak + 1 : 0;
                if (m_streak >= t) begin
                    m_locked = 1'b1;
                    m_chans  = q;
                    m_first  = '0;
                    for (int i = 2; i >= 0; i--) if (q[i]) m_first = 2'(i);
                end
            end
        end
    endtask

    task automatic clear_cycle();
        quiet_inputs();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        thr   = 16'd1;
        rst_n = 1'b0;
        model_zero();
        #12;
        checks++; if (block !== 1'b0) begin errors++; $display("FAIL reset_block got %b want 0", block); end
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL reset_deadlock got %b want 0", deadlock); end
        checks++; if (chans !== 3'b000) begin errors++; $display("FAIL reset_chans got %b want 000", chans); end
        checks++; if (first !== 2'd0) begin errors++; $display("FAIL reset_first got %0d want 0", first); end
        checks++; if (stall !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
        axis = 3'b100;
        cycle();
        checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL pre_reset_lock got %b want 1", deadlock); end
        rst_n = 1'b0;
        model_zero();
        #1;
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL async_reset_deadlock got %b want 0", deadlock); end
        checks++; if (block !== 1'b0 || chans !== 3'b000 || stall !== 4'd0) begin
            errors++; $display("FAIL async_reset_outs got block=%b chans=%b stall=%0d want 0/000/0", block, chans, stall);
        end
        axis = 3'b000;
        #1;
        rst_n = 1'b1;
        cycle();
        checks++; if (block !== 1'b0) begin errors++; $display("FAIL post_reset_block got %b want 0", block); end
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL post_reset_deadlock got %b want 0", deadlock); end
    endtask

    task automatic test_persist();
        clear_cycle();
        thr  = 16'd4;
        axis = 3'b010;
        cycle();
        checks++; if (block !== 1'b1) begin errors++; $display("FAIL persist_block_c1 got %b want 1", block); end
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL persist_early_c1 got %b want 0", deadlock); end
        cycle();
        cycle();
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL persist_early_c3 got %b want 0", deadlock); end
        cycle();
        checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL persist_lock_c4 got %b want 1", deadlock); end
        checks++; if (chans !== 3'b010) begin errors++; $display("FAIL persist_chans got %b want 010", chans); end
        checks++; if (first !== 2'd1) begin errors++; $display("FAIL persist_first got %0d want 1", first); end
        checks++; if (stall !== 4'd4) begin errors++; $display("FAIL persist_stall got %0d want 4", stall); end
        axis = 3'b000;
        cycle();
        checks++; if (deadlock !== 1'b1 || chans !== 3'b010) begin
            errors++; $display("FAIL persist_sticky got dl=%b chans=%b want 1/010", deadlock, chans);
        end
    endtask

    task automatic test_restart();
        logic seen;
        clear_cycle();
        thr  = 16'd4;
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            axis = (i == 3) ? 3'b000 : 3'b001;
            cycle();
            if (deadlock) seen = 1'b1;
        end
        axis = 3'b000;
        cycle();
        if (deadlock) seen = 1'b1;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL restart_no_lock got %b want 0", seen); end
        checks++; if (stall !== 4'd6) begin errors++; $display("FAIL restart_stall got %0d want 6", stall); end
    endtask

    task automatic test_idle_mask();
        logic any_block;
        clear_cycle();
        thr  = 16'd2;
        axis = 3'b101;
        idle = 3'b001;
        cycle();
        cycle();
        checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL idle_lock got %b want 1", deadlock); end
        checks++; if (chans !== 3'b100) begin errors++; $display("FAIL idle_chans got %b want 100", chans); end
        checks++; if (first !== 2'd2) begin errors++; $display("FAIL idle_first got %0d want 2", first); end
        clear_cycle();
        axis = 3'b101;
        idle = 3'b001;
        mask = 3'b011;
        any_block = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (block) any_block = 1'b1;
        end
        checks++; if (any_block !== 1'b0) begin errors++; $display("FAIL mask_block got %b want 0", any_block); end
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL mask_deadlock got %b want 0", deadlock); end
    endtask

    task automatic test_clear_relock();
        clear_cycle();
        thr  = 16'd1;
        axis = 3'b001;
        cycle();
        checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL relock_pre got %b want 1", deadlock); end
        clear = 1'b1;
        thr   = 16'd2;
        cycle();
        clear = 1'b0;
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL clear_deadlock got %b want 0", deadlock); end
        checks++; if (stall !== 4'd0) begin errors++; $display("FAIL clear_stall got %0d want 0", stall); end
        checks++; if (block !== 1'b1) begin errors++; $display("FAIL clear_block got %b want 1", block); end
        cycle();
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL relock_c1 got %b want 0", deadlock); end
        cycle();
        checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL relock_c2 got %b want 1", deadlock); end
        checks++; if (stall !== 4'd2) begin errors++; $display("FAIL relock_stall got %0d want 2", stall); end
    endtask

    task automatic test_saturate();
        clear_cycle();
        thr  = 16'd100;
        axis = 3'b111;
        for (int i = 0; i < 20; i++) cycle();
        checks++; if (stall !== 4'd15) begin errors++; $display("FAIL sat_stall got %0d want 15", stall); end
        checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL sat_deadlock got %b want 0", deadlock); end
    endtask

    task automatic test_inst_only();
        clear_cycle();
        thr  = 16'd0;
        inst = 2'b01;
        cycle();
        checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL inst_lock got %b want 1", deadlock); end
        checks++; if (block !== 1'b1) begin errors++; $display("FAIL inst_block got %b want 1", block); end
        checks++; if (chans !== 3'b000) begin errors++; $display("FAIL inst_chans got %b want 000", chans); end
        checks++; if (first !== 2'd0) begin errors++; $display("FAIL inst_first got %0d want 0", first); end
    endtask

    task automatic test_random();
        clear_cycle();
        thr = 16'(int'($urandom_range(0, 5)));
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) axis = 3'($urandom_range(0, 7));
            idle  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            mask  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            inst  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            clear = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) thr = 16'(int'($urandom_range(0, 5)));
            cycle();
            checks++; if (block !== m_block) begin errors++; $display("FAIL rnd_block n=%0d got %b want %b", n, block, m_block); end
            checks++; if (deadlock !== m_locked) begin errors++; $display("FAIL rnd_deadlock n=%0d got %b want %b", n, deadlock, m_locked); end
            checks++; if (chans !== m_chans) begin errors++; $display("FAIL rnd_chans n=%0d got %b want %b", n, chans, m_chans); end
            checks++; if (first !== m_first) begin errors++; $display("FAIL rnd_first n=%0d got %0d want %0d", n, first, m_first); end
            checks++; if (int'(stall) !== m_stall) begin errors++; $display("FAIL rnd_stall n=%0d got %0d want %0d", n, stall, m_stall); end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_persist();
        test_restart();
        test_idle_mask();
        test_clear_relock();
        test_saturate();
        test_inst_only();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
